// File: rtl/hdlc_pkg.sv
// Shared HDLC definitions for the transmit and receive channels: state
// encoding, flag, CRC-16/CCITT constants and the length slots in the buffer.
package hdlc_pkg;
  typedef enum logic [3:0] {
    S_IDLE, S_LEN_LO, S_LEN_HI, S_CHECK, S_PRE, S_DATA, S_FCS, S_CLOSE, S_DONE
  } state_t;

  localparam logic [7:0]  FLAG        = 8'h7E;
  localparam logic [15:0] CRC_POLY    = 16'h1021;
  localparam logic [15:0] CRC_PRESET  = 16'hFFFF;
  localparam logic [8:0]  ADDR_LEN_LO = 9'd510;
  localparam logic [8:0]  ADDR_LEN_HI = 9'd511;

  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
    return {c[14:0], 1'b0} ^ ((b ^ c[15]) ? CRC_POLY : 16'h0000);
  endfunction
endpackage

// File: rtl/hdlc_crc16_bit.sv
// Bit-serial CRC-16/CCITT register, one bit per enable; shared with the receiver.
module hdlc_crc16_bit
  import hdlc_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        init,
  input  logic        en,
  input  logic        din,
  output logic [15:0] crc
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       crc <= CRC_PRESET;
    else if (init) crc <= CRC_PRESET;
    else if (en)   crc <= crc_step(crc, din);
  end
endmodule

// File: rtl/hdlctx.sv
// HDLC frame transmitter: buffer RAM -> flags, stuffed payload, FCS, flag on datat.
// Option HDLC_TX_IDLE_FLAG_EN: datat carries continuous flags between frames.
module hdlctx
  import hdlc_pkg::*;
#(
  parameter int unsigned PRE_FLAGS = 1,
  parameter logic [8:0]  MAX_LEN   = 9'd508
) (
  input  logic       clkt,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] ramq,
  output logic [8:0] rama,
  output logic       hrd,
  output logic       datat,
  output logic       flagt,
  output logic       busy,
  output logic       done,
  output logic       err
);
  state_t      state, state_nx;
  logic [2:0]  bi, ones;
  logic [8:0]  cnt, len, len_c;
  logic [7:0]  lo, cur, nxt;
  logic [15:0] crc;
  logic        rd_vld, bad, stuff, last_bit, pay_bit, idle_bit, hold, crc_init, crc_en;

  assign len_c    = {ramq[0], lo};
  assign bad      = (len_c == 9'd0) || (len_c > MAX_LEN);
  assign stuff    = (state inside {S_DATA, S_FCS, S_CLOSE}) && (ones == 3'd5);
  assign last_bit = (bi == 3'd7);
  assign pay_bit  = (state == S_FCS) ? crc[~cnt[3:0]] : cur[bi];

`ifdef HDLC_TX_IDLE_FLAG_EN
  // Idle flags run freely; a frame waits in PRE until the idle flag wraps.
  logic [2:0] ip;
  assign idle_bit = FLAG[ip];
  assign hold     = (state == S_PRE) && !flagt && (ip != 3'd0);
  always_ff @(posedge clkt or posedge rst) begin
    if (rst) ip <= 3'd0;
    else if (hold || (state inside {S_IDLE, S_LEN_LO, S_LEN_HI, S_CHECK, S_DONE}))
      ip <= ip + 3'd1;
  end
`else
  assign idle_bit = 1'b1;
  assign hold     = 1'b0;
`endif

  hdlc_crc16_bit u_crc (
    .clk(clkt), .rst(rst), .init(crc_init), .en(crc_en), .din(cur[bi]), .crc(crc)
  );

  always_comb begin
    state_nx = state;
    crc_init = 1'b0;
    crc_en   = 1'b0;
    case (state)
      S_IDLE:   if (start) state_nx = S_LEN_LO;
      S_LEN_LO: state_nx = S_LEN_HI;
      S_LEN_HI: state_nx = S_CHECK;
      S_CHECK:  if (bi == 3'd1) begin
        state_nx = bad ? S_IDLE : S_PRE;
        crc_init = !bad;
      end
      S_PRE:    if (!hold && last_bit && cnt == 9'(PRE_FLAGS - 1)) state_nx = S_DATA;
      S_DATA: begin
        crc_en = !stuff;
        if (!stuff && last_bit && cnt == len - 9'd1) state_nx = S_FCS;
      end
      S_FCS:    if (!stuff && cnt == 9'd15) state_nx = S_CLOSE;
      S_CLOSE:  if (!stuff && last_bit) state_nx = S_DONE;
      S_DONE:   state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clkt or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      rama  <= '0;   hrd  <= 1'b0; datat <= 1'b1; flagt <= 1'b0;
      busy  <= 1'b0; done <= 1'b0; err   <= 1'b0;
      bi    <= '0;   ones <= '0;   cnt   <= '0;   len   <= '0;
      lo    <= '0;   cur  <= '0;   nxt   <= '0;   rd_vld <= 1'b0;
    end else begin
      state  <= state_nx;
      hrd    <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
      rd_vld <= hrd;
      if (rd_vld) nxt <= ramq;
      case (state)
        S_IDLE: begin
          datat <= idle_bit;
          if (start) busy <= 1'b1;
        end
        S_LEN_LO: begin datat <= idle_bit; rama <= ADDR_LEN_LO; hrd <= 1'b1; end
        S_LEN_HI: begin datat <= idle_bit; rama <= ADDR_LEN_HI; hrd <= 1'b1; end
        S_CHECK: begin
          datat <= idle_bit;
          bi    <= bi + 3'd1;
          if (bi == 3'd0) lo <= ramq;
          else begin
            len <= len_c; bi <= 3'd0; cnt <= 9'd0;
            if (bad) begin err <= 1'b1; busy <= 1'b0; end
            else begin rama <= 9'd0; hrd <= 1'b1; end
          end
        end
        S_PRE: if (hold) datat <= idle_bit;
        else begin
          datat <= FLAG[bi];
          flagt <= 1'b1;
          bi    <= bi + 3'd1;
          if (last_bit) begin
            if (state_nx == S_DATA) begin
              cnt <= 9'd0; ones <= 3'd0; cur <= nxt; rama <= 9'd1; hrd <= (len > 9'd1);
            end else cnt <= cnt + 9'd1;
          end
        end
        S_DATA, S_FCS: if (stuff) begin
          datat <= 1'b0; ones <= 3'd0;
        end else begin
          datat <= pay_bit;
          ones  <= pay_bit ? ones + 3'd1 : 3'd0;
          if (state == S_FCS) cnt <= cnt + 9'd1;
          else begin
            bi <= bi + 3'd1;
            // Byte n+1 is already in nxt; fetch n+2 while n+1 shifts.
            if (last_bit) begin
              if (state_nx == S_FCS) cnt <= 9'd0;
              else begin
                cnt  <= cnt + 9'd1;
                cur  <= nxt;
                rama <= cnt + 9'd2;
                hrd  <= ({1'b0, cnt} + 10'd2) < {1'b0, len};
              end
            end
          end
        end
        S_CLOSE: if (stuff) begin
          datat <= 1'b0; ones <= 3'd0;
        end else begin
          datat <= FLAG[bi]; bi <= bi + 3'd1;
        end
        S_DONE: begin
          datat <= idle_bit; flagt <= 1'b0; busy <= 1'b0; done <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_hdlctx.sv
// Bench for hdlctx: buffer RAM model, wire-level frame model and a behavioural receiver.
module tb_hdlctx;
  localparam int PF = 1;

  logic       clkt = 1'b0, rst = 1'b1, start = 1'b0;
  logic [7:0] ramq = 8'h00;
  logic [8:0] rama;
  logic       hrd, datat, flagt, busy, done, err;

  logic [7:0] mem    [0:511];
  logic [7:0] rx_mem [0:511];
  bit         cap[$], exp_q[$];
  int         n_chk = 0, n_fail = 0;
  int         n_done, n_err, last_rise, last_kend;
  logic [9:0] last_a1, last_a2;

  typedef struct { logic [7:0] q510; logic [7:0] q511; bit exp_err; } lvec_t;
  lvec_t tv[7];

  always #5 clkt = ~clkt;
  always @(posedge clkt) if (hrd) ramq <= mem[rama];

  hdlctx #(.PRE_FLAGS(PF), .MAX_LEN(9'd508)) dut (
    .clkt(clkt), .rst(rst), .start(start), .ramq(ramq), .rama(rama), .hrd(hrd),
    .datat(datat), .flagt(flagt), .busy(busy), .done(done), .err(err)
  );

  task automatic chk(input string name, input int act, input int expv);
    n_chk++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  task automatic chk_q(input string name);
    int diff = -1;
    n_chk++;
    if (cap.size() == exp_q.size())
      foreach (cap[i]) if (diff < 0 && cap[i] != exp_q[i]) diff = i;
    if (cap.size() != exp_q.size() || diff >= 0) begin
      n_fail++;
      $display("FAIL %s: got %0d bits (first diff at %0d), expected %0d bits",
               name, cap.size(), diff, exp_q.size());
    end
  endtask

  task automatic set_len(input int len);
    logic [8:0] l9 = len[8:0];
    mem[510] = l9[7:0];
    mem[511] = {7'd0, l9[8]};
  endtask

  // Expected wire bits while flagt is high, built straight from the frame rules.
  task automatic build_exp(input int len);
    bit pl[$];
    logic [15:0] c = 16'hFFFF;
    logic [7:0]  f = 8'h7E;
    int ones = 0;
    bit fb;
    exp_q.delete();
    for (int p = 0; p < PF; p++) for (int i = 0; i < 8; i++) exp_q.push_back(f[i]);
    for (int n = 0; n < len; n++) for (int i = 0; i < 8; i++) pl.push_back(mem[n][i]);
    foreach (pl[j]) begin
      fb = pl[j] ^ c[15];
      c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    end
    for (int i = 15; i >= 0; i--) pl.push_back(c[i]);
    foreach (pl[j]) begin
      exp_q.push_back(pl[j]);
      ones = pl[j] ? ones + 1 : 0;
      if (ones == 5) begin exp_q.push_back(1'b0); ones = 0; end
    end
    for (int i = 0; i < 8; i++) exp_q.push_back(f[i]);
  endtask

  // Receiver: strip flags, destuff, check CRC residue, store bytes and count.
  task automatic rx_decode(output int resid);
    bit d[$];
    logic [15:0] c = 16'hFFFF;
    logic [8:0]  nb9;
    int ones = 0, nb = 0;
    bit fb;
    for (int i = 8 * PF; i < cap.size() - 8; i++) begin
      if (ones == 5) begin ones = 0; continue; end
      d.push_back(cap[i]);
      ones = cap[i] ? ones + 1 : 0;
    end
    foreach (d[j]) begin
      fb = d[j] ^ c[15];
      c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    end
    resid = int'(c);
    if (d.size() >= 16) nb = (d.size() - 16) / 8;
    for (int n = 0; n < nb; n++) for (int i = 0; i < 8; i++) rx_mem[n][i] = d[8 * n + i];
    nb9 = nb[8:0];
    rx_mem[510] = nb9[7:0];
    rx_mem[511] = {7'd0, nb9[8]};
  endtask

  task automatic run_frame(input int max_cyc, input int restart_at);
    cap.delete(); n_done = 0; n_err = 0; last_rise = -1; last_kend = 0;
    last_a1 = '0; last_a2 = '0;
    @(posedge clkt); #2 start = 1'b1;
    @(posedge clkt); #1 start = 1'b0;
    for (int k = 1; k <= max_cyc; k++) begin
      @(posedge clkt); #1;
      start = (k == restart_at);
      if (k == 1) last_a1 = {hrd, rama};
      if (k == 2) last_a2 = {hrd, rama};
      if (flagt) begin
        if (last_rise < 0) last_rise = k;
        cap.push_back(datat);
      end
      if (done) n_done++;
      if (err) n_err++;
      last_kend = k;
      if (!busy) break;
    end
    start = 1'b0;
  endtask

  task automatic do_frame(input string tag, input int len, input int restart_at);
    int resid;
    bit ok = 1'b1;
    build_exp(len);
    run_frame(len * 12 + 100, restart_at);
    chk_q({tag, "_wire"});
    chk({tag, "_done"}, n_done, 1);
    chk({tag, "_err"}, n_err, 0);
    chk({tag, "_busy_end"}, int'(busy), 0);
    rx_decode(resid);
    chk({tag, "_rx_crc"}, resid, 0);
    for (int i = 0; i < len; i++) if (rx_mem[i] !== mem[i]) ok = 1'b0;
    chk({tag, "_rx_bytes"}, int'(ok), 1);
    chk({tag, "_rx_len"}, int'({rx_mem[511][0], rx_mem[510]}), len);
  endtask

  initial begin
    logic [40:0] g0;
    logic [8:0]  gff;
    int len, seen;
    bit ok;

    tv[0] = '{8'h00, 8'h00, 1'b1};
    tv[1] = '{8'hFE, 8'h01, 1'b1};
    tv[2] = '{8'hFD, 8'h01, 1'b1};
    tv[3] = '{8'hFF, 8'hFF, 1'b1};
    tv[4] = '{8'h02, 8'h00, 1'b0};
    tv[5] = '{8'h03, 8'hFE, 1'b0};
    tv[6] = '{8'hFC, 8'h01, 1'b0};
    for (int i = 0; i < 512; i++) mem[i] = 8'h00;

    // Reset state
    repeat (3) @(posedge clkt);
    #1 chk("reset_outputs", int'({rama, hrd, datat, flagt, busy, done, err}),
           int'({9'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}));
    #1 rst = 1'b0;

    // Single 0x00 byte; the FCS E1F0 contains five 1s so one 0 is stuffed.
    g0 = 41'b01111110_00000000_11100001111100000_01111110;
    mem[0] = 8'h00; set_len(1);
    do_frame("f00", 1, -1);
    ok = (cap.size() == 41);
    if (ok) for (int i = 0; i < 41; i++) if (cap[i] != g0[40 - i]) ok = 1'b0;
    chk("f00_golden", int'(ok), 1);
    chk("f00_flag_rise", last_rise, 5);
    chk("f00_len_rd_lo", int'(last_a1), int'({1'b1, 9'd510}));
    chk("f00_len_rd_hi", int'(last_a2), int'({1'b1, 9'd511}));
    chk("f00_frame_cycles", cap.size(), 41);

    // Single 0xFF byte: 11111 0 111 after the opening flag
    gff = 9'b111110111;
    mem[0] = 8'hFF; set_len(1);
    do_frame("fff", 1, -1);
    ok = (cap.size() > 17);
    if (ok) for (int i = 0; i < 9; i++) if (cap[8 + i] != gff[8 - i]) ok = 1'b0;
    chk("fff_stuffed_payload", int'(ok), 1);

    // Length table: rejects and boundary accepts
    foreach (tv[t]) begin
      mem[510] = tv[t].q510; mem[511] = tv[t].q511;
      len = int'({tv[t].q511[0], tv[t].q510});
      if (tv[t].exp_err) begin
        run_frame(20, -1);
        chk($sformatf("len%0d_err", t), n_err, 1);
        chk($sformatf("len%0d_no_flag", t), cap.size(), 0);
        chk($sformatf("len%0d_no_done", t), n_done, 0);
        chk($sformatf("len%0d_busy_fall", t), int'(!busy && last_kend <= 4), 1);
      end else begin
        for (int i = 0; i < len; i++) mem[i] = 8'($urandom);
        do_frame($sformatf("len%0d", t), len, -1);
      end
    end

    // Loopback pattern with flag / escape look-alikes
    mem[0] = 8'h7E; mem[1] = 8'h7D; mem[2] = 8'hFF; mem[3] = 8'h00; mem[4] = 8'h55;
    set_len(5);
    do_frame("loop", 5, -1);

    // Random frames, biased toward 0xFF to exercise stuffing
    for (int r = 0; r < 6; r++) begin
      len = $urandom_range(1, 40);
      for (int i = 0; i < len; i++) mem[i] = ($urandom_range(0, 1) == 1) ? 8'hFF : 8'($urandom);
      set_len(len);
      do_frame($sformatf("rnd%0d", r), len, -1);
    end

    // Second start mid-frame is ignored
    len = 6;
    for (int i = 0; i < len; i++) mem[i] = 8'($urandom);
    set_len(len);
    do_frame("restart", len, 25);
    seen = 0;
    repeat (20) begin
      @(posedge clkt); #1;
      if (flagt || busy) seen++;
    end
    chk("restart_no_second_frame", seen, 0);

    // Reset in the middle of DATA
    len = 20;
    for (int i = 0; i < len; i++) mem[i] = 8'($urandom);
    set_len(len);
    run_frame(30, -1);
    chk("rst_mid_in_frame", int'(flagt & busy), 1);
    #2 rst = 1'b1;
    #1 chk("rst_mid_outputs", int'({rama, hrd, datat, flagt, busy, done, err}),
           int'({9'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}));
    @(posedge clkt); #2 rst = 1'b0;
    do_frame("after_rst", len, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
